// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrated mux: ring-index arithmetic
// that stays within 0..n-1 for any channel count, power of two or not.
package rr_arb_mux_pkg;

  // Offset a ring index by off positions, wrapping modulo n (base, off < n).
  function automatic int unsigned ring_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

  // Ring index that follows idx, wrapping back to 0 after n-1.
  function automatic int unsigned ring_next(input int unsigned idx,
                                            input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage : rr_arb_mux_pkg

// File: rtl/rr_arb_mux_arbiter.sv
// Round-robin grant selection. The search starts at rr_ptr and wraps; the
// pointer only moves when the parent reports that the grant was consumed.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter  int unsigned N_INS     = 2,
  localparam int unsigned SEL_WIDTH = $clog2(N_INS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_INS-1:0]     req,
  input  logic                 advance,
  output logic [N_INS-1:0]     grant_onehot,
  output logic [SEL_WIDTH-1:0] grant_idx
);

  logic [SEL_WIDTH-1:0] rr_ptr_q;
  logic [SEL_WIDTH-1:0] rr_ptr_d;
  logic [SEL_WIDTH-1:0] cand_idx;
  int unsigned          cand;
  logic                 found;

  // First requester at or after rr_ptr, in wrap-around order.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = '0;
    cand_idx     = '0;
    found        = 1'b0;
    for (int unsigned k = 0; k < N_INS; k++) begin
      cand     = ring_add(32'(rr_ptr_q), k, N_INS);
      cand_idx = SEL_WIDTH'(cand);
      if (!found && req[cand_idx]) begin
        found                  = 1'b1;
        grant_idx              = cand_idx;
        grant_onehot[cand_idx] = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the consumed grant; holds otherwise.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = SEL_WIDTH'(ring_next(32'(grant_idx), N_INS));
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : rr_arbiter

// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated N-to-1 mux feeding a single-entry output register.
// The register reloads in the same cycle it is drained, so a continuous
// stream moves one payload per clock. ins[i] is channel i's payload.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int unsigned WIDTH     = 1,
  parameter  int unsigned N_INS     = 2,
  localparam int unsigned SEL_WIDTH = $clog2(N_INS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_INS-1:0][WIDTH-1:0] ins,
  input  logic [N_INS-1:0]            in_valid,
  output logic [N_INS-1:0]            in_ready,
  output logic [WIDTH-1:0]            out,
  output logic [SEL_WIDTH-1:0]        out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [N_INS-1:0]     grant_onehot;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 load_c;
  logic [WIDTH-1:0]     out_next_c;

  logic [WIDTH-1:0]     out_q,       out_d;
  logic [SEL_WIDTH-1:0] out_sel_q,   out_sel_d;
  logic                 out_valid_q, out_valid_d;

  rr_arbiter #(
    .N_INS (N_INS)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (in_valid),
    .advance      (load_c),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  // Accept when anyone requests and the slot is empty or draining now;
  // nothing is accepted while reset is held.
  always_comb begin
    load_c     = (|in_valid) && (!out_valid_q || out_ready) && !rst;
    in_ready   = grant_onehot & {N_INS{load_c}};
    out_next_c = ins[grant_idx];
  end

  // Output slot next state: load wins, else a drain clears valid, else hold.
  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load_c) begin
      out_d       = out_next_c;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule : rr_arb_mux

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a 3-channel instance for directed scenarios and a
// 5-channel instance for a randomized soak, both fed from shared stimulus.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4:0]      vld;
  logic [4:0][7:0] ins5;
  logic            out_ready;

  logic [2:0] rdy3;  logic [7:0] o3;  logic [1:0] sel3;  logic ov3;
  logic [4:0] rdy5;  logic [7:0] o5;  logic [2:0] sel5;  logic ov5;

  rr_arb_mux #(.WIDTH(8), .N_INS(3)) u_dut3 (
    .clk(clk), .rst(rst), .ins(ins5[2:0]), .in_valid(vld[2:0]),
    .in_ready(rdy3), .out(o3), .out_sel(sel3), .out_valid(ov3),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(8), .N_INS(5)) u_dut5 (
    .clk(clk), .rst(rst), .ins(ins5), .in_valid(vld),
    .in_ready(rdy5), .out(o5), .out_sel(sel5), .out_valid(ov5),
    .out_ready(out_ready)
  );

  int n_act = 3;

  logic [4:0] rdy;
  logic [7:0] o;
  int         sel;
  logic       ov;
  int         ptr;

  always_comb begin
    if (n_act == 3) begin
      rdy = {2'b00, rdy3};
      o   = o3;
      sel = int'(sel3);
      ov  = ov3;
      ptr = int'(u_dut3.u_arb.rr_ptr_q);
    end else begin
      rdy = rdy5;
      o   = o5;
      sel = int'(sel5);
      ov  = ov5;
      ptr = int'(u_dut5.u_arb.rr_ptr_q);
    end
  end

  typedef struct {
    logic [7:0] data;
    int         sel;
  } item_t;

  item_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         order_en = 1'b0;
  bit         m_valid;
  int         m_ptr;
  bit         m_load;
  logic [4:0] m_acc;
  logic [7:0] m_last;
  int         m_last_sel;
  int         w[5];
  int         max_wait;
  int         seq[5];
  int         exp_seq[5];
  int         pop_cnt;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, want, want, $time);
    end
  endtask

  // Reference grant: first valid channel scanning up from the pointer, mod n.
  function automatic int model_grant(input logic [4:0] v);
    for (int k = 0; k < n_act; k++) begin
      int c;
      c = (m_ptr + k) % n_act;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: predict acceptance, check in_ready and pointer, then update model.
  task automatic cycle();
    int         g;
    logic [4:0] v;
    logic [4:0] exp_rdy;
    @(negedge clk);
    v       = vld & 5'((1 << n_act) - 1);
    g       = model_grant(v);
    m_load  = (v != 5'd0) && (!m_valid || out_ready);
    exp_rdy = m_load ? 5'(1 << g) : 5'd0;
    m_acc   = exp_rdy;
    chk("in_ready", int'(rdy), int'(exp_rdy));
    chk("rr_ptr", ptr, m_ptr);
    chk("ptr_range", int'(ptr < n_act), 1);
    if (m_load) exp_q.push_back('{data: ins5[g], sel: g});
    @(posedge clk);
    if (m_load) begin
      for (int c = 0; c < n_act; c++) begin
        if (c == g || !v[c]) w[c] = 0;
        else begin
          w[c]++;
          if (w[c] > max_wait) max_wait = w[c];
        end
      end
      m_valid = 1'b1;
      m_ptr   = (g + 1) % n_act;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Asynchronous reset between edges, with requests pending to show gating.
  task automatic do_reset();
    mon_en    = 1'b0;
    vld       = 5'b11111;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_out", int'(o), 0);
    chk("rst_out_sel", sel, 0);
    chk("rst_in_ready", int'(rdy), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", int'(ov), 0);
    chk("rst_ptr", ptr, 0);
    rst        = 1'b0;
    vld        = 5'd0;
    m_valid    = 1'b0;
    m_ptr      = 0;
    m_last     = 8'd0;
    m_last_sel = 0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) w[c] = 0;
    mon_en = 1'b1;
  endtask

  // Monitor: compares the presented entry with the scoreboard head, pops on
  // each output transfer, and checks held values while the slot is empty.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", int'(ov), int'(m_valid));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 0, 1);
        end else begin
          chk("out_data", int'(o), int'(exp_q[0].data));
          chk("out_sel", sel, exp_q[0].sel);
          if (out_ready) begin
            m_last     = exp_q[0].data;
            m_last_sel = exp_q[0].sel;
            if (order_en) begin
              chk("chan_order", int'(exp_q[0].data[4:0]),
                  exp_seq[exp_q[0].data[7:5]] % 32);
              exp_seq[exp_q[0].data[7:5]]++;
            end
            pop_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("hold_out", int'(o), int'(m_last));
        chk("hold_sel", sel, m_last_sel);
      end
    end
  end

  initial begin
    int total;
    rst       = 1'b1;
    vld       = 5'd0;
    ins5      = '0;
    out_ready = 1'b0;
    n_act     = 3;
    max_wait  = 0;
    pop_cnt   = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Saturated traffic: rotating grants, one transfer per cycle.
    ins5[0] = 8'h11; ins5[1] = 8'h22; ins5[2] = 8'h33;
    vld = 5'b00111; out_ready = 1'b1;
    repeat (4) cycle();
    chk("sat_out", int'(o), 8'h11);
    chk("sat_sel", sel, 0);

    // Backpressure, then release with same-cycle reload.
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    repeat (2) cycle();

    // Wrap skip: move pointer to 2, then only ch0/ch1 request.
    vld = 5'b00000;
    repeat (2) cycle();
    vld = 5'b00010;
    cycle();
    chk("pre_wrap_ptr", ptr, 2);
    vld = 5'b00011;
    cycle();
    chk("wrap_sel", sel, 0);
    chk("wrap_ptr", ptr, 1);

    // Sparse single pulse on ch1.
    vld = 5'b00000;
    repeat (2) cycle();
    ins5[1] = 8'h5C;
    vld = 5'b00010;
    cycle();
    vld = 5'b00000;
    chk("sparse_valid", int'(ov), 1);
    chk("sparse_out", int'(o), 8'h5C);
    chk("sparse_sel", sel, 1);
    cycle();
    chk("sparse_drop", int'(ov), 0);
    chk("sparse_hold", int'(o), 8'h5C);
    repeat (2) cycle();

    // Reset with an entry held in the slot.
    ins5[0] = 8'hAA;
    vld = 5'b00001; out_ready = 1'b0;
    cycle();
    vld = 5'b00000;
    chk("pre_rst_valid", int'(ov), 1);
    chk("pre_rst_out", int'(o), 8'hAA);
    do_reset();

    // First load after reset grants lowest valid index.
    ins5[1] = 8'h44; ins5[2] = 8'h55;
    vld = 5'b00110; out_ready = 1'b1;
    cycle();
    chk("post_rst_sel", sel, 1);
    vld = 5'b00000;
    repeat (2) cycle();

    // Randomized soak on the 5-channel instance.
    n_act = 5;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      seq[c] = 0;
      exp_seq[c] = 0;
    end
    max_wait = 0;
    pop_cnt  = 0;
    order_en = 1'b1;
    repeat (3000) begin
      for (int c = 0; c < 5; c++) begin
        if (!vld[c] && ($urandom_range(0, 1) == 1)) begin
          vld[c]  = 1'b1;
          ins5[c] = {3'(c), 5'(seq[c])};
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      for (int c = 0; c < 5; c++) begin
        if (m_acc[c]) begin
          vld[c] = 1'b0;
          seq[c]++;
        end
      end
    end
    vld = 5'd0;
    out_ready = 1'b1;
    repeat (3) cycle();
    total = 0;
    for (int c = 0; c < 5; c++) total += seq[c];
    chk("drain_empty", exp_q.size(), 0);
    chk("no_loss", pop_cnt, total);
    chk("max_wait", int'(max_wait <= 4), 1);
    chk("soak_activity", int'(total > 1000), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_arb_mux
